// File: rtl/opvc_ctrl.sv
// Odd/even virtual-channel output controller: the phase pushes into VC[polarity] and pops from VC[~polarity].
// Optional feature macro: OPVC_GRANT_CHECK_EN (sticky illegal-grant detector on grant_err).
module opvc_ctrl #(
    parameter int DATA_W = 64,
    parameter int NUM_IN = 5,
    parameter int DEPTH  = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     polarity,
    input  logic [NUM_IN-1:0]        grant,
    input  logic [NUM_IN*DATA_W-1:0] data_in,
    input  logic                     receive_output,
    output logic [DATA_W-1:0]        data_out,
    output logic                     send_output,
    output logic [NUM_IN-1:0]        clear,
    output logic [1:0]               full,
    output logic [1:0]               empty,
    output logic                     grant_err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic              grant_nonzero;
    logic              grant_onehot;
    logic              push_ok;
    logic              pop_ok;
    logic [DATA_W-1:0] sel_flit;
    logic [DATA_W-1:0] masked_flit [NUM_IN];
    logic [DATA_W-1:0] head_flit   [2];

    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              send_q, send_d;
    logic [NUM_IN-1:0] clear_q, clear_d;

    assign grant_nonzero = (grant != '0);
    assign grant_onehot  = grant_nonzero && ((grant & (grant - 1'b1)) == '0);

    // AND-OR flit mux; only meaningful when the grant is one-hot.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_IN; gi++) begin : g_mask
            assign masked_flit[gi] = grant[gi] ? data_in[gi*DATA_W +: DATA_W] : '0;
        end
    endgenerate

    always_comb begin
        sel_flit = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            sel_flit = sel_flit | masked_flit[i];
        end
    end

    assign push_ok = grant_onehot && !full[polarity];
    assign pop_ok  = receive_output && !empty[!polarity];

    generate
        for (gi = 0; gi < 2; gi++) begin : g_vc
            logic [DATA_W-1:0] mem [DEPTH];
            logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
            logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
            logic [CW-1:0]     cnt_q, cnt_d;
            logic              push_v;
            logic              pop_v;

            assign push_v = push_ok && (polarity == 1'(gi));
            assign pop_v  = pop_ok  && (polarity != 1'(gi));

            assign full[gi]      = (cnt_q == FULL_CNT);
            assign empty[gi]     = (cnt_q == '0);
            assign head_flit[gi] = mem[rd_ptr_q];

            // Push and pop never hit the same VC in one cycle, so count moves by at most one.
            always_comb begin
                wr_ptr_d = wr_ptr_q;
                rd_ptr_d = rd_ptr_q;
                cnt_d    = cnt_q;
                if (push_v) begin
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    cnt_d    = cnt_q + 1'b1;
                end
                if (pop_v) begin
                    rd_ptr_d = rd_ptr_q + 1'b1;
                    cnt_d    = cnt_q - 1'b1;
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    wr_ptr_q <= '0;
                    rd_ptr_q <= '0;
                    cnt_q    <= '0;
                end else begin
                    wr_ptr_q <= wr_ptr_d;
                    rd_ptr_q <= rd_ptr_d;
                    cnt_q    <= cnt_d;
                end
            end

            // Storage carries no reset so it can map onto RAM; reset still blocks the write.
            always_ff @(posedge clk) begin
                if (push_v && !reset) begin
                    mem[wr_ptr_q] <= sel_flit;
                end
            end
        end
    endgenerate

    always_comb begin
        data_out_d = data_out_q;
        send_d     = 1'b0;
        clear_d    = '0;
        if (pop_ok) begin
            data_out_d = head_flit[!polarity];
            send_d     = 1'b1;
        end
        if (push_ok) begin
            clear_d = grant;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_out_q <= '0;
            send_q     <= 1'b0;
            clear_q    <= '0;
        end else begin
            data_out_q <= data_out_d;
            send_q     <= send_d;
            clear_q    <= clear_d;
        end
    end

    assign data_out    = data_out_q;
    assign send_output = send_q;
    assign clear       = clear_q;

`ifdef OPVC_GRANT_CHECK_EN
    logic grant_err_q, grant_err_d;

    always_comb begin
        grant_err_d = grant_err_q;
        if (grant_nonzero && !grant_onehot) begin
            grant_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            grant_err_q <= 1'b0;
        end else begin
            grant_err_q <= grant_err_d;
        end
    end

    assign grant_err = grant_err_q;
`else
    assign grant_err = 1'b0;
`endif

endmodule

// File: tb/tb_opvc_ctrl.sv
// Directed bench for opvc_ctrl: fixed vectors with hand-derived expectations, one line per step.
module tb_opvc_ctrl;

    localparam int DATA_W = 64;
    localparam int NUM_IN = 5;
    localparam int DEPTH  = 2;

`ifdef OPVC_GRANT_CHECK_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     polarity;
    logic [NUM_IN-1:0]        grant;
    logic [NUM_IN*DATA_W-1:0] data_in;
    logic                     receive_output;
    logic [DATA_W-1:0]        data_out;
    logic                     send_output;
    logic [NUM_IN-1:0]        clear;
    logic [1:0]               full;
    logic [1:0]               empty;
    logic                     grant_err;

    int checks = 0;
    int errors = 0;

    opvc_ctrl #(.DATA_W(DATA_W), .NUM_IN(NUM_IN), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .polarity       (polarity),
        .grant          (grant),
        .data_in        (data_in),
        .receive_output (receive_output),
        .data_out       (data_out),
        .send_output    (send_output),
        .clear          (clear),
        .full           (full),
        .empty          (empty),
        .grant_err      (grant_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s failed", tag);
        end
    endtask

    // Apply inputs, then sample 1 time unit after the rising edge.
    task automatic step(input logic rst, input logic pol, input logic [NUM_IN-1:0] g,
                        input int port, input logic [63:0] flit, input logic rcv);
        @(negedge clk);
        reset          = rst;
        polarity       = pol;
        grant          = g;
        data_in        = '0;
        data_in[port*DATA_W +: DATA_W] = flit;
        receive_output = rcv;
        @(posedge clk);
        #1;
        $display("step rst=%0b pol=%0b grant=%05b rcv=%0b -> send=%0b dout=%0h clear=%05b full=%02b empty=%02b err=%0b",
                 rst, pol, g, rcv, send_output, data_out, clear, full, empty, grant_err);
    endtask

    initial begin
        reset = 1'b1; polarity = 1'b0; grant = '0; data_in = '0; receive_output = 1'b0;

        // Reset then idle
        step(1, 0, 5'b00000, 0, 64'h0, 0);
        step(0, 0, 5'b00000, 0, 64'h0, 0);
        chk("idle_empty", 64'(empty), 64'(2'b11));
        chk("idle_full",  64'(full),  64'(2'b00));
        chk("idle_send",  64'(send_output), 64'h0);
        chk("idle_clear", 64'(clear), 64'h0);
        chk("idle_dout",  data_out, 64'h0);
        chk("idle_err",   64'(grant_err), 64'h0);

        // Single flit from N into VC0, read out on odd phase
        step(0, 0, 5'b00100, 2, 64'hA5, 0);
        chk("n_clear",  64'(clear), 64'(5'b00100));
        chk("n_empty",  64'(empty), 64'(2'b10));
        step(0, 1, 5'b00000, 0, 64'h0, 1);
        chk("n_send",   64'(send_output), 64'h1);
        chk("n_dout",   data_out, 64'hA5);
        chk("n_clear0", 64'(clear), 64'h0);
        chk("n_emptyb", 64'(empty), 64'(2'b11));

        // Fill VC0 past DEPTH; third push must be refused
        step(0, 0, 5'b00001, 0, 64'h11, 0);
        chk("f1_clear", 64'(clear), 64'(5'b00001));
        step(0, 0, 5'b00001, 0, 64'h22, 0);
        chk("f2_clear", 64'(clear), 64'(5'b00001));
        chk("f2_full",  64'(full), 64'(2'b01));
        step(0, 0, 5'b00001, 0, 64'h33, 0);
        chk("f3_clear", 64'(clear), 64'h0);
        chk("f3_full",  64'(full), 64'(2'b01));
        chk("f3_send",  64'(send_output), 64'h0);
        step(0, 1, 5'b00000, 0, 64'h0, 1);
        chk("d1_dout",  data_out, 64'h11);
        step(0, 1, 5'b00000, 0, 64'h0, 1);
        chk("d2_dout",  data_out, 64'h22);
        chk("d2_empty", 64'(empty), 64'(2'b11));
        step(0, 1, 5'b00000, 0, 64'h0, 1);
        chk("d3_send",  64'(send_output), 64'h0);
        chk("d3_hold",  data_out, 64'h22);

        // Simultaneous push to VC1 and pop from VC0
        step(0, 0, 5'b00001, 0, 64'h44, 0);
        chk("s0_clear", 64'(clear), 64'(5'b00001));
        step(0, 1, 5'b10000, 4, 64'h55, 1);
        chk("s1_send",  64'(send_output), 64'h1);
        chk("s1_dout",  data_out, 64'h44);
        chk("s1_clear", 64'(clear), 64'(5'b10000));
        chk("s1_empty", 64'(empty), 64'(2'b01));
        step(0, 0, 5'b00000, 0, 64'h0, 1);
        chk("s2_dout",  data_out, 64'h55);
        chk("s2_empty", 64'(empty), 64'(2'b11));

        // Illegal two-hot grant is dropped
        step(0, 0, 5'b00011, 0, 64'h66, 0);
        chk("g_clear",  64'(clear), 64'h0);
        chk("g_empty",  64'(empty), 64'(2'b11));
        chk("g_err",    64'(grant_err), 64'(ERR_EXP));
        step(0, 0, 5'b00000, 0, 64'h0, 0);
        chk("g_errheld", 64'(grant_err), 64'(ERR_EXP));

        // Reset overrides concurrent push and pop with both VCs occupied
        step(0, 0, 5'b00010, 1, 64'h77, 0);
        step(0, 1, 5'b01000, 3, 64'h88, 0);
        chk("r_pre_empty", 64'(empty), 64'(2'b00));
        step(1, 0, 5'b00001, 0, 64'h99, 1);
        chk("r_send",  64'(send_output), 64'h0);
        chk("r_empty", 64'(empty), 64'(2'b11));
        chk("r_clear", 64'(clear), 64'h0);
        chk("r_dout",  data_out, 64'h0);
        chk("r_err",   64'(grant_err), 64'h0);
        step(0, 1, 5'b00000, 0, 64'h0, 1);
        chk("r_post_send", 64'(send_output), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
